// File: rtl/btn_sw_conditioner.sv
// Button/switch input conditioning: 2-FF sync, debounce,
// rise/fall event pulses and hold-to-repeat pulses per channel.
module btn_sw_conditioner #(
  parameter int              WIDTH           = 5,
  parameter int              DEBOUNCE_CYCLES = 1250000,
  parameter int              HOLD_CYCLES     = 62500000,
  parameter int              REPEAT_CYCLES   = 12500000,
  parameter logic [WIDTH-1:0] REPEAT_MASK    = 5'b11100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] rpt
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD =
    HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Two-stage synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_raw;
      s2 <= s2_next(s1);
    end
  end

  function automatic logic [WIDTH-1:0] s2_next(
    input logic [WIDTH-1:0] v
  );
    return v;
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic            lvl_q;
    logic            rise_q;
    logic            fall_q;
    logic [DB_W-1:0] db_cnt;
    logic            differ;
    logic            settle;

    assign differ = s2[i] != lvl_q;
    assign settle = differ && (db_cnt == DB_LAST);

    // Debounce counter; level and edge pulses move together
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        db_cnt <= '0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (!differ) begin
          db_cnt <= '0;
        end else if (settle) begin
          lvl_q  <= s2[i];
          rise_q <= s2[i];
          fall_q <= ~s2[i];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    assign level[i] = lvl_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;

    if (REPEAT_MASK[i]) begin : g_rpt
      logic              rpt_q;
      logic [HOLD_W-1:0] hold_cnt;

      // Hold timer; a release in progress wins over a due repeat
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rpt_q    <= 1'b0;
          hold_cnt <= '0;
        end else if (!lvl_q || settle) begin
          rpt_q    <= 1'b0;
          hold_cnt <= '0;
        end else if (hold_cnt == HOLD_LAST) begin
          rpt_q    <= 1'b1;
          hold_cnt <= HOLD_RELOAD;
        end else begin
          rpt_q    <= 1'b0;
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end

      assign rpt[i] = rpt_q;
    end else begin : g_norpt
      assign rpt[i] = 1'b0;
    end
  end

endmodule
